// File: rtl/layer7_pixel_buffer_pkg.sv
// Definitions shared between the layer6 pooling stage and the layer7 consumer.
// Port summary: none (package only).
// Holds word width, pixel word width, feature-map dimension and buffer-state type.
package layer7_pixel_buffer_pkg;

    localparam int WORDLENGTH           = 16;
    localparam int LAYER6_OUTPUT_LENGTH = 128;  // 8 channels x 16 bit
    localparam int LAYER7_DIM           = 8;

    typedef enum logic [1:0] {
        BUF_IDLE,
        BUF_FILL,
        BUF_READY
    } buf_state_t;

endpackage

// File: rtl/layer7_pixel_buffer_pixel_ram_1w1r.sv
// Purpose: 1-write/1-read register array with a registered read port.
// Ports: wr_en/wr_addr/wr_data write at the clock edge; rd_en/rd_addr fetch into rd_data
//        one cycle later (rd_zero forces 0); rd_data holds its value when rd_en is low.
module pixel_ram_1w1r
    import layer7_pixel_buffer_pkg::*;
#(
    parameter int DEPTH  = LAYER7_DIM * LAYER7_DIM,
    parameter int DATA_W = LAYER6_OUTPUT_LENGTH,
    parameter int AW     = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en,
    input  logic [AW-1:0]     wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              rd_en,
    input  logic              rd_zero,
    input  logic [AW-1:0]     rd_addr,
    output logic [DATA_W-1:0] rd_data
);

    // Storage is deliberately not reset.
    logic [DATA_W-1:0] mem [DEPTH];
    logic [DATA_W-1:0] rd_data_d, rd_data_q;

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    always_comb begin
        rd_data_d = rd_data_q;
        if (rd_en) begin
            rd_data_d = rd_zero ? '0 : mem[rd_addr];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_data_q <= '0;
        end else begin
            rd_data_q <= rd_data_d;
        end
    end

    assign rd_data = rd_data_q;

endmodule

// File: rtl/layer7_pixel_buffer.sv
// Purpose: frame store between layer6 pooling and the layer7 consumer; fills, announces the
//          frame with a one-cycle pixel_store_done, then serves 1-cycle registered reads.
// Ports: save_* write side, layer_done_in upstream done, read_* / consumer_done consumer side,
//        read_data/read_valid read result, buf_ready level, err_flag sticky protocol error.
module layer7_pixel_buffer
    import layer7_pixel_buffer_pkg::*;
#(
    parameter int OUT_DIM = LAYER7_DIM,
    parameter int DATA_W  = LAYER6_OUTPUT_LENGTH,
    parameter int ADDR_W  = WORDLENGTH
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              save_enable,
    input  logic [ADDR_W-1:0] save_row,
    input  logic [ADDR_W-1:0] save_col,
    input  logic [DATA_W-1:0] save_data,
    input  logic              layer_done_in,
    input  logic              read_pixel_signal,
    input  logic [ADDR_W-1:0] read_row_addr,
    input  logic [ADDR_W-1:0] read_col_addr,
    input  logic              consumer_done,
    output logic [DATA_W-1:0] read_data,
    output logic              read_valid,
    output logic              pixel_store_done,
    output logic              buf_ready,
    output logic              err_flag
);

    localparam int NPIX  = OUT_DIM * OUT_DIM;
    localparam int RC_W  = $clog2(OUT_DIM);
    localparam int IDX_W = $clog2(NPIX);
    localparam int CNT_W = $clog2(NPIX + 1);

    buf_state_t       state_d, state_q;
    logic [CNT_W-1:0] cnt_d, cnt_q;
    logic             seen_done_d, seen_done_q;
    logic             read_valid_d, read_valid_q;
    logic             store_done_d, store_done_q;
    logic             err_d, err_q;

    logic             is_ready;
    logic             wr_in_range, rd_in_range;
    logic             wr_en, rd_en;
    logic [IDX_W-1:0] wr_idx, rd_idx;

    assign is_ready    = (state_q == BUF_READY);
    assign wr_in_range = (save_row < ADDR_W'(OUT_DIM)) && (save_col < ADDR_W'(OUT_DIM));
    assign rd_in_range = (read_row_addr < ADDR_W'(OUT_DIM)) && (read_col_addr < ADDR_W'(OUT_DIM));

    // Only the low RC_W bits matter once the address is known to be in range.
    assign wr_idx = IDX_W'(save_row[RC_W-1:0]) * IDX_W'(OUT_DIM) + IDX_W'(save_col[RC_W-1:0]);
    assign rd_idx = IDX_W'(read_row_addr[RC_W-1:0]) * IDX_W'(OUT_DIM)
                  + IDX_W'(read_col_addr[RC_W-1:0]);

    assign wr_en = !is_ready && save_enable && wr_in_range;
    assign rd_en = is_ready && read_pixel_signal;

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        seen_done_d  = seen_done_q;
        store_done_d = 1'b0;
        read_valid_d = rd_en;
        err_d        = err_q;

        if (save_enable && (is_ready || !wr_in_range)) begin
            err_d = 1'b1;
        end
        if (read_pixel_signal && (!is_ready || !rd_in_range)) begin
            err_d = 1'b1;
        end

        case (state_q)
            BUF_IDLE, BUF_FILL: begin
                if (wr_en) begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
                if (layer_done_in) begin
                    seen_done_d = 1'b1;
                end
                if (state_q == BUF_IDLE && wr_en) begin
                    state_d = BUF_FILL;
                end
                // Uses the post-edge count and done flag so a final write and a done
                // pulse in the same cycle complete the frame at that edge.
                if (state_q == BUF_FILL && cnt_d == CNT_W'(NPIX) && seen_done_d) begin
                    state_d      = BUF_READY;
                    store_done_d = 1'b1;
                end
            end
            BUF_READY: begin
                if (consumer_done) begin
                    state_d     = BUF_IDLE;
                    cnt_d       = '0;
                    seen_done_d = 1'b0;
                end
            end
            default: state_d = BUF_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= BUF_IDLE;
            cnt_q        <= '0;
            seen_done_q  <= 1'b0;
            read_valid_q <= 1'b0;
            store_done_q <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            seen_done_q  <= seen_done_d;
            read_valid_q <= read_valid_d;
            store_done_q <= store_done_d;
            err_q        <= err_d;
        end
    end

    pixel_ram_1w1r #(
        .DEPTH  (NPIX),
        .DATA_W (DATA_W),
        .AW     (IDX_W)
    ) u_ram (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (wr_en),
        .wr_addr (wr_idx),
        .wr_data (save_data),
        .rd_en   (rd_en),
        .rd_zero (!rd_in_range),
        .rd_addr (rd_idx),
        .rd_data (read_data)
    );

    assign read_valid       = read_valid_q;
    assign pixel_store_done = store_done_q;
    assign buf_ready        = is_ready;
    assign err_flag         = err_q;

endmodule

// File: tb/tb_layer7_pixel_buffer.sv
module tb_layer7_pixel_buffer;

    logic         clk = 1'b0;
    logic         rst;
    logic         save_enable;
    logic [15:0]  save_row, save_col;
    logic [127:0] save_data;
    logic         layer_done_in;
    logic         read_pixel_signal;
    logic [15:0]  read_row_addr, read_col_addr;
    logic         consumer_done;
    logic [127:0] read_data;
    logic         read_valid, pixel_store_done, buf_ready, err_flag;

    always #5 clk = ~clk;

    layer7_pixel_buffer dut (
        .clk               (clk),
        .rst               (rst),
        .save_enable       (save_enable),
        .save_row          (save_row),
        .save_col          (save_col),
        .save_data         (save_data),
        .layer_done_in     (layer_done_in),
        .read_pixel_signal (read_pixel_signal),
        .read_row_addr     (read_row_addr),
        .read_col_addr     (read_col_addr),
        .consumer_done     (consumer_done),
        .read_data         (read_data),
        .read_valid        (read_valid),
        .pixel_store_done  (pixel_store_done),
        .buf_ready         (buf_ready),
        .err_flag          (err_flag)
    );

    // Reference model: frame contents, accepted-write tally, done-seen flag, readable flag.
    logic [127:0] m_mem [64];
    int           m_cnt;
    bit           m_seen, m_ready;
    logic [127:0] e_data;
    bit           e_valid, e_done, e_err;

    int n_vec = 0;
    int n_bad = 0;
    int n_pulse = 0;

    typedef struct {
        logic         rd;
        logic [15:0]  row;
        logic [15:0]  col;
        logic         cdone;
        logic         exp_valid;
        logic [127:0] exp_data;
        logic         exp_ready;
        logic         exp_err;
    } vec_t;
    vec_t tbl [8];

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic chk_all(input string tag);
        chk({tag, " read_valid"}, 128'(read_valid), 128'(e_valid));
        chk({tag, " read_data"}, read_data, e_data);
        chk({tag, " pixel_store_done"}, 128'(pixel_store_done), 128'(e_done));
        chk({tag, " buf_ready"}, 128'(buf_ready), 128'(m_ready));
        chk({tag, " err_flag"}, 128'(err_flag), 128'(e_err));
    endtask

    task automatic model_reset();
        m_cnt = 0; m_seen = 0; m_ready = 0;
        e_data = '0; e_valid = 0; e_done = 0; e_err = 0;
    endtask

    // Applies the buffer rules to the inputs present before the coming edge.
    task automatic model_step();
        bit in_w, in_r;
        in_w = (save_row < 8) && (save_col < 8);
        in_r = (read_row_addr < 8) && (read_col_addr < 8);
        e_done = 0;
        if (m_ready) begin
            e_valid = read_pixel_signal;
            if (read_pixel_signal) begin
                e_data = in_r ? m_mem[int'(read_row_addr) * 8 + int'(read_col_addr)] : '0;
                if (!in_r) e_err = 1;
            end
            if (save_enable) e_err = 1;
            if (consumer_done) begin
                m_ready = 0; m_cnt = 0; m_seen = 0;
            end
        end else begin
            e_valid = 0;
            if (read_pixel_signal) e_err = 1;
            if (save_enable) begin
                if (in_w) begin
                    m_mem[int'(save_row) * 8 + int'(save_col)] = save_data;
                    m_cnt++;
                end else begin
                    e_err = 1;
                end
            end
            if (layer_done_in) m_seen = 1;
            if (m_cnt == 64 && m_seen) begin
                m_ready = 1;
                e_done  = 1;
            end
        end
    endtask

    task automatic idle_inputs();
        save_enable = 0; save_row = '0; save_col = '0; save_data = '0;
        layer_done_in = 0; read_pixel_signal = 0; read_row_addr = '0; read_col_addr = '0;
        consumer_done = 0;
    endtask

    task automatic tick(input string tag);
        model_step();
        @(posedge clk);
        #1;
        if (pixel_store_done) n_pulse++;
        chk_all(tag);
    endtask

    task automatic do_reset();
        idle_inputs();
        rst = 1;
        #2;
        model_reset();
        chk_all("reset");
        @(posedge clk);
        #1;
        rst = 0;
    endtask

    task automatic wr(input int row, input int col, input logic [127:0] data, input bit done);
        save_enable = 1; save_row = 16'(row); save_col = 16'(col); save_data = data;
        layer_done_in = done;
        tick("write");
        idle_inputs();
    endtask

    task automatic rd(input int row, input int col, input bit cdone);
        read_pixel_signal = 1; read_row_addr = 16'(row); read_col_addr = 16'(col);
        consumer_done = cdone;
        tick("read");
        idle_inputs();
    endtask

    initial begin
        tbl[0] = '{1, 16'd0, 16'd0, 0, 1, {8{16'd0}},  1, 0};
        tbl[1] = '{1, 16'd7, 16'd0, 0, 1, {8{16'd56}}, 1, 0};
        tbl[2] = '{0, 16'd0, 16'd0, 0, 0, {8{16'd56}}, 1, 0};
        tbl[3] = '{1, 16'd0, 16'd9, 0, 1, 128'd0,      1, 1};
        tbl[4] = '{1, 16'd8, 16'd8, 0, 1, 128'd0,      1, 1};
        tbl[5] = '{1, 16'd2, 16'd6, 0, 1, {8{16'd22}}, 1, 1};
        tbl[6] = '{1, 16'd7, 16'd7, 1, 1, {8{16'd63}}, 0, 1};
        tbl[7] = '{1, 16'd1, 16'd1, 0, 0, {8{16'd63}}, 0, 1};

        for (int i = 0; i < 64; i++) m_mem[i] = '0;
        do_reset();

        // Frame 1: full row-major fill, done pulse afterwards.
        for (int i = 0; i < 64; i++) wr(i / 8, i % 8, {8{16'(i)}}, 0);
        chk("ready_before_done", 128'(buf_ready), 128'(0));
        layer_done_in = 1;
        tick("done");
        idle_inputs();
        chk("store_done_pulse", 128'(pixel_store_done), 128'(1));
        chk("buf_ready_set", 128'(buf_ready), 128'(1));
        tick("after_done");
        chk("store_done_single", 128'(pixel_store_done), 128'(0));
        rd(3, 5, 0);
        chk("rd_3_5_data", read_data, {8{16'd29}});
        chk("rd_3_5_valid", 128'(read_valid), 128'(1));

        // Streaming reads, one per cycle.
        for (int i = 0; i < 64; i++) begin
            read_pixel_signal = 1; read_row_addr = 16'(i / 8); read_col_addr = 16'(i % 8);
            tick("stream");
            chk("stream_valid", 128'(read_valid), 128'(1));
            chk("stream_data", read_data, {8{16'(i)}});
        end
        idle_inputs();
        tick("stream_end");

        // Table: reads, out-of-range reads, release concurrent with a read.
        for (int i = 0; i < 8; i++) begin
            read_pixel_signal = tbl[i].rd;
            read_row_addr = tbl[i].row; read_col_addr = tbl[i].col;
            consumer_done = tbl[i].cdone;
            tick("table");
            idle_inputs();
            chk("tbl_valid", 128'(read_valid), 128'(tbl[i].exp_valid));
            chk("tbl_data", read_data, tbl[i].exp_data);
            chk("tbl_ready", 128'(buf_ready), 128'(tbl[i].exp_ready));
            chk("tbl_err", 128'(err_flag), 128'(tbl[i].exp_err));
        end

        // Frame 2: early done, out-of-range write mid-fill.
        do_reset();
        for (int i = 0; i < 10; i++) wr(i / 8, i % 8, {8{16'(i) + 16'h0100}}, 0);
        layer_done_in = 1;
        tick("early_done");
        idle_inputs();
        wr(8, 0, {8{16'hdead}}, 0);
        chk("oor_write_err", 128'(err_flag), 128'(1));
        for (int i = 10; i < 64; i++) begin
            if (i == 63) chk("no_done_before_last", 128'(pixel_store_done | buf_ready), 128'(0));
            wr(i / 8, i % 8, {8{16'(i) + 16'h0100}}, 0);
        end
        chk("early_done_pulse", 128'(pixel_store_done), 128'(1));
        rd(0, 9, 0);
        chk("oor_read_data", read_data, 128'd0);
        chk("oor_read_valid", 128'(read_valid), 128'(1));
        rd(4, 4, 1);
        chk("frame2_rd_4_4", read_data, {8{16'd36 + 16'h0100}});
        chk("released", 128'(buf_ready), 128'(0));

        // Reset mid-fill, then a complete frame with done on the final write.
        for (int i = 0; i < 30; i++) wr(i / 8, i % 8, {8{16'(i) + 16'h0200}}, 0);
        do_reset();
        chk("mid_rst_outputs", {read_data[123:0], read_valid, pixel_store_done, buf_ready, err_flag},
            128'd0);
        n_pulse = 0;
        for (int i = 0; i < 64; i++) wr(i / 8, i % 8, {8{16'(i) + 16'h0300}}, i == 63);
        chk("same_cycle_done", 128'(pixel_store_done), 128'(1));
        for (int i = 0; i < 4; i++) tick("settle");
        chk("one_pulse", 128'(n_pulse), 128'(1));
        consumer_done = 1;
        tick("release3");
        idle_inputs();

        // Randomized traffic against the model.
        for (int c = 0; c < 1500; c++) begin
            if (!m_ready && m_cnt >= 64) save_enable = 0;
            else if (!m_ready) save_enable = ($urandom_range(0, 3) != 0);
            else save_enable = ($urandom_range(0, 15) == 0);
            save_row = 16'($urandom_range(0, 8));
            save_col = 16'($urandom_range(0, 8));
            save_data = {$urandom, $urandom, $urandom, $urandom};
            layer_done_in = ($urandom_range(0, 19) == 0);
            read_pixel_signal = m_ready ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 31) == 0);
            read_row_addr = 16'($urandom_range(0, 8));
            read_col_addr = 16'($urandom_range(0, 8));
            consumer_done = m_ready && ($urandom_range(0, 11) == 0);
            tick("random");
            if (c % 500 == 499) do_reset();
        end
        idle_inputs();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
